// File: rtl/inst_enc.sv
// miniRV instruction encoder: turns field-level requests into 32-bit words
// with sequential byte addresses on a valid/ready stream; li expands to 1-2 words.
module inst_enc #(
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [3:0]        req_funct,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_ALU_IMM = 4'd1;
  localparam logic [3:0] OP_ALU_REG = 4'd2;
  localparam logic [3:0] OP_LOAD    = 4'd3;
  localparam logic [3:0] OP_STORE   = 4'd4;
  localparam logic [3:0] OP_LUI     = 4'd5;
  localparam logic [3:0] OP_JALR    = 4'd6;
  localparam logic [3:0] OP_EBREAK  = 4'd7;
  localparam logic [3:0] OP_LI      = 4'd8;

  localparam logic [6:0] OPC_IMM   = 7'h13;
  localparam logic [6:0] OPC_REG   = 7'h33;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_JALR  = 7'h67;

  typedef enum logic [0:0] {IDLE = 1'b0, SECOND = 1'b1} state_t;

  typedef struct packed {
    logic        legal;
    logic        two;
    logic [31:0] first;
    logic [31:0] second;
  } enc_t;

  function automatic enc_t encode(input logic [3:0] op, input logic [3:0] funct,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm);
    enc_t        e;
    logic [2:0]  f3;
    logic        sub;
    logic        fits12;
    logic        shamt_ok;
    logic [19:0] hi20;
    e        = '0;
    f3       = funct[2:0];
    sub      = funct[3];
    fits12   = (imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF);
    shamt_ok = (imm[31:5] == 27'h0);
    // Rounding the upper part up when imm[11] is set compensates the sign-extended addi.
    hi20     = imm[31:12] + {19'h0, imm[11]};
    case (op)
      OP_NOP: begin
        e.legal = 1'b1;
        e.first = 32'h0000_0013;
      end
      OP_EBREAK: begin
        e.legal = 1'b1;
        e.first = 32'h0010_0073;
      end
      OP_ALU_IMM: begin
        case (f3)
          3'b001: begin
            e.legal = !sub && shamt_ok;
            e.first = {7'h00, imm[4:0], rs1, f3, rd, OPC_IMM};
          end
          3'b101: begin
            e.legal = shamt_ok;
            e.first = {1'b0, sub, 5'b00000, imm[4:0], rs1, f3, rd, OPC_IMM};
          end
          default: begin
            e.legal = fits12;
            e.first = {imm[11:0], rs1, f3, rd, OPC_IMM};
          end
        endcase
      end
      OP_ALU_REG: begin
        e.legal = !sub || (f3 == 3'b000) || (f3 == 3'b101);
        e.first = {1'b0, sub, 5'b00000, rs2, rs1, f3, rd, OPC_REG};
      end
      OP_LOAD: begin
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: e.legal = fits12;
          default: e.legal = 1'b0;
        endcase
        e.first = {imm[11:0], rs1, f3, rd, OPC_LOAD};
      end
      OP_STORE: begin
        e.legal = fits12 && ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010));
        e.first = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      end
      OP_LUI: begin
        e.legal = (imm[11:0] == 12'h000);
        e.first = {imm[31:12], rd, OPC_LUI};
      end
      OP_JALR: begin
        e.legal = fits12 && (f3 == 3'b000);
        e.first = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      end
      OP_LI: begin
        e.legal = 1'b1;
        if (fits12) begin
          e.first = {imm[11:0], 5'd0, 3'b000, rd, OPC_IMM};
        end else begin
          e.first  = {hi20, rd, OPC_LUI};
          e.two    = (imm[11:0] != 12'h000);
          e.second = {imm[11:0], rd, 3'b000, rd, OPC_IMM};
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  state_t            state_r, state_s;
  logic [31:0]       pend_r, pend_s;
  logic              valid_s, err_s, out_hs_s, accept_s;
  logic [31:0]       inst_s;
  logic [ADDR_W-1:0] addr_s;
  enc_t              enc_s;

  assign req_ready = (state_r == IDLE) & (!out_valid | out_ready);
  assign out_hs_s  = out_valid & out_ready;
  assign accept_s  = req_valid & req_ready;

  // Next-state and next-output computation for the encoder FSM.
  always_comb begin
    enc_s   = encode(req_op, req_funct, req_rd, req_rs1, req_rs2, req_imm);
    state_s = state_r;
    pend_s  = pend_r;
    valid_s = out_valid;
    inst_s  = out_inst;
    err_s   = err;
    if (out_hs_s) begin
      addr_s = out_addr + ADDR_W'(4);
    end else begin
      addr_s = out_addr;
    end
    case (state_r)
      SECOND: begin
        if (out_hs_s) begin
          inst_s  = pend_r;
          state_s = IDLE;
        end else begin
          state_s = SECOND;
        end
      end
      IDLE: begin
        if (accept_s && enc_s.legal) begin
          valid_s = 1'b1;
          inst_s  = enc_s.first;
          if (enc_s.two) begin
            state_s = SECOND;
            pend_s  = enc_s.second;
          end else begin
            state_s = IDLE;
          end
        end else if (accept_s) begin
          err_s = 1'b1;
          if (out_hs_s) begin
            valid_s = 1'b0;
          end else begin
            valid_s = out_valid;
          end
        end else if (out_hs_s) begin
          valid_s = 1'b0;
        end else begin
          valid_s = out_valid;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      pend_r    <= 32'h0;
      out_valid <= 1'b0;
      out_inst  <= 32'h0;
      out_addr  <= BASE;
      err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      pend_r    <= pend_s;
      out_valid <= valid_s;
      out_inst  <= inst_s;
      out_addr  <= addr_s;
      err       <= err_s;
    end
  end

endmodule

// File: tb/tb_inst_enc.sv
// Directed self-checking bench for inst_enc; a second instance with ADDR_W=4
// covers the address wrap.
module tb_inst_enc;

  logic        clock = 1'b0;
  logic        reset_n, req_valid, w_req_valid, out_ready;
  logic [3:0]  req_op, req_funct;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        req_ready, out_valid, err;
  logic [31:0] out_inst;
  logic [15:0] out_addr;
  logic        w_req_ready, w_out_valid, w_err;
  logic [31:0] w_out_inst;
  logic [3:0]  w_out_addr;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  inst_enc #(.ADDR_W(16), .BASE_ADDR(0)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_funct(req_funct), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err(err)
  );

  inst_enc #(.ADDR_W(4), .BASE_ADDR(0)) dut_w (
    .clock(clock), .reset_n(reset_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_op(req_op), .req_funct(req_funct), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_inst(w_out_inst), .out_addr(w_out_addr), .err(w_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one request for a single edge; the target must be ready.
  task automatic send(input bit w, input logic [3:0] op, input logic [3:0] funct,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    req_op = op; req_funct = funct; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    if (w) w_req_valid = 1'b1;
    else   req_valid = 1'b1;
    #1;
    if (w) chk("w_req_ready", {31'h0, w_req_ready}, 32'h1);
    else   chk("req_ready", {31'h0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0;
    w_req_valid = 1'b0;
  endtask

  task automatic word(input string tag, input logic [31:0] inst, input logic [31:0] addr);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({tag, "_inst"}, out_inst, inst);
    chk({tag, "_addr"}, {16'h0, out_addr}, addr);
  endtask

  task automatic idle_at(input string tag, input logic [31:0] addr, input logic e);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_addr"}, {16'h0, out_addr}, addr);
    chk({tag, "_err"}, {31'h0, err}, {31'h0, e});
  endtask

  logic [31:0] wrap_exp [5] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0};

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; w_req_valid = 1'b0; out_ready = 1'b1;
    req_op = 4'd0; req_funct = 4'd0; req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0;
    req_imm = 32'd0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    idle_at("reset", 32'd0, 1'b0);
    chk("reset_inst", out_inst, 32'h0);
    chk("reset_ready", {31'h0, req_ready}, 32'h1);

    // Back-to-back legal words with out_ready high.
    send(1'b0, 4'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5);
    word("addi", 32'h0050_0093, 32'd0);
    send(1'b0, 4'd1, 4'b1101, 5'd2, 5'd1, 5'd0, 32'd3);
    word("srai", 32'h4030_D113, 32'd4);
    send(1'b0, 4'd4, 4'b0010, 5'd0, 5'd1, 5'd2, 32'd8);
    word("sw", 32'h0020_A423, 32'd8);
    send(1'b0, 4'd3, 4'b0010, 5'd3, 5'd1, 5'd0, 32'hFFFF_FFFC);
    word("lw", 32'hFFC0_A183, 32'd12);
    send(1'b0, 4'd2, 4'b1000, 5'd4, 5'd1, 5'd2, 32'd0);
    word("sub", 32'h4020_8233, 32'd16);
    send(1'b0, 4'd5, 4'b0000, 5'd8, 5'd0, 5'd0, 32'h1234_5000);
    word("lui", 32'h1234_5437, 32'd20);
    tick();
    idle_at("drain1", 32'd24, 1'b0);

    // Two-word li held under backpressure.
    out_ready = 1'b0;
    send(1'b0, 4'd8, 4'b0000, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    word("li_hi", 32'h1234_62B7, 32'd24);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", {31'h0, req_ready}, 32'h0);
      tick();
      word("li_stall", 32'h1234_62B7, 32'd24);
    end
    out_ready = 1'b1;
    #1;
    chk("second_ready", {31'h0, req_ready}, 32'h0);
    tick();
    word("li_lo", 32'hFFF2_8293, 32'd28);
    chk("after_second_ready", {31'h0, req_ready}, 32'h1);
    tick();
    idle_at("drain2", 32'd32, 1'b0);

    // Single-word li forms.
    send(1'b0, 4'd8, 4'b0000, 5'd6, 5'd0, 5'd0, 32'h0001_2000);
    word("li_x6", 32'h0001_2337, 32'd32);
    send(1'b0, 4'd8, 4'b0000, 5'd7, 5'd0, 5'd0, 32'hFFFF_FFFF);
    word("li_x7", 32'hFFF0_0393, 32'd36);
    tick();
    idle_at("drain3", 32'd40, 1'b0);

    // Illegal requests: accepted, no word, address held, err sticky.
    send(1'b0, 4'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd2048);
    idle_at("ill_imm", 32'd40, 1'b1);
    send(1'b0, 4'd2, 4'b1001, 5'd1, 5'd2, 5'd3, 32'd0);
    idle_at("ill_sub", 32'd40, 1'b1);
    send(1'b0, 4'd5, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h0000_1001);
    idle_at("ill_lui", 32'd40, 1'b1);
    send(1'b0, 4'd12, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd0);
    idle_at("ill_op", 32'd40, 1'b1);
    send(1'b0, 4'd0, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0);
    word("nop", 32'h0000_0013, 32'd40);
    chk("err_sticky", {31'h0, err}, 32'h1);
    tick();

    // Reset while the second li word is pending.
    out_ready = 1'b0;
    send(1'b0, 4'd8, 4'b0000, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    word("li_pre_reset", 32'h1234_62B7, 32'd44);
    reset_n = 1'b0;
    tick();
    idle_at("mid_reset", 32'd0, 1'b0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_reset_ready", {31'h0, req_ready}, 32'h1);
    send(1'b0, 4'd7, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0);
    word("ebreak", 32'h0010_0073, 32'd0);
    tick();
    idle_at("discarded", 32'd4, 1'b0);

    // Address wrap on the 4-bit instance.
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 4'd0, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0);
      chk("wrap_valid", {31'h0, w_out_valid}, 32'h1);
      chk("wrap_inst", w_out_inst, 32'h0000_0013);
      chk("wrap_addr", {28'h0, w_out_addr}, wrap_exp[i]);
    end
    chk("wrap_err", {31'h0, w_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_enc.md
# inst_enc

Instruction encoder for the miniRV core: the inverse of the instruction decoder. Accepts field-level instruction requests (operation class, register ids, funct, immediate), checks their legality, and emits 32-bit miniRV words with sequential byte addresses through a valid/ready stream. The stream feeds instruction-memory preload and self-test program generation. The `li` pseudo-op expands to one or two words.

## Interface
- `ADDR_W`, 16, width of `out_addr` (byte address).
- `BASE_ADDR`, 0, address of the first emitted word after reset.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_op`  in  4  operation class: 0 NOP, 1 ALU_IMM, 2 ALU_REG, 3 LOAD, 4 STORE, 5 LUI, 6 JALR, 7 EBREAK, 8 LI; 9–15 illegal.
- `req_funct`  in  4  `{sub, funct3}`, same packing as the decoder's `alu_op`.
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register ids.
- `req_imm`  in  32  immediate, full-width signed value.
- `out_valid`  out  1  encoded word present.
- `out_ready`  in  1  consumer ready.
- `out_inst`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  byte address of `out_inst`.
- `err`  out  1  sticky; set by any rejected request.

## Operation
- **States**
  - IDLE: no word pending behind the output register.
  - SECOND: the second word of an LI is pending.
- **Request acceptance**
  - `req_ready = (state==IDLE) & (!out_valid | out_ready)`.
  - An accepted legal request loads the output register and sets `out_valid`.
  - An accepted illegal request sets `err`, produces no word and leaves `out_addr` unchanged.
- **Encodings** (imm12 means `req_imm` must lie in [-2048, 2047]; otherwise the request is illegal)
  - NOP: 0x00000013.
  - EBREAK: 0x00100073.
  - ALU_IMM: opcode 0x13, imm12.
    - funct3 001/101 (shifts): need `req_imm` in [0, 31]; imm[11:0] = `{1'b0, sub, 5'b0, imm[4:0]}`.
    - `sub` with funct3 001 is illegal.
    - `sub` is ignored for non-shift funct3 values.
  - ALU_REG: opcode 0x33, funct7 = `{1'b0, sub, 5'b0}`. `sub` is legal only with funct3 000 or 101.
  - LOAD: opcode 0x03, funct3 in {000, 001, 010, 100, 101}, imm12.
  - STORE: opcode 0x23, funct3 in {000, 001, 010}, imm12 split as imm[11:5] → inst[31:25] and imm[4:0] → inst[11:7].
  - LUI: opcode 0x37, inst[31:12] = `req_imm[31:12]`. `req_imm[11:0] != 0` is illegal.
  - JALR: opcode 0x67, funct3 000, imm12.
  - LI:
    - If `req_imm` fits imm12: emit one word, `addi rd, x0, imm`.
    - Otherwise compute `hi = (req_imm + 0x800) >> 12`, modulo 32 bits.
    - Emit `lui rd, hi`.
    - If `req_imm[11:0] != 0`, enter SECOND and emit `addi rd, rd, req_imm[11:0]` next.
    - `req_rd == 0` with LI is legal (it encodes writes to x0).
  - Fields not used by an encoding are zero regardless of the request inputs.
- **Address**
  - `out_addr` starts at BASE_ADDR.
  - It advances by 4 on each output handshake (`out_valid & out_ready`) and wraps modulo 2^ADDR_W.
- **SECOND state**
  - The second word is loaded on the handshake of the first word, so `out_valid` stays high and there is no bubble.
  - The state then returns to IDLE.

## Timing
- Latency: a request accepted at edge N has `out_valid` and the word visible after edge N. This gives back-to-back throughput of 1 word per cycle while `out_ready` is high.
- `out_inst` and `out_addr` hold stable while `out_valid & !out_ready`.
- `req_ready` is combinational from `state`, `out_valid` and `out_ready`. `out_*` are registered.
- `err` is set at the edge that accepts an illegal request and stays high until reset.
- Reset (`reset_n` low at an edge), including mid-LI:
  - `out_valid=0`, `out_inst=0`, `out_addr=BASE_ADDR`, `err=0`, state IDLE.
  - Any pending second word is discarded.
  - `req_ready` is 1 after the first edge with `reset_n` high.
- Address wrap: after the word at 2^ADDR_W−4 handshakes, `out_addr` becomes 0.

## Test plan
- **ALU_IMM, STORE, LOAD:**
  - addi x1,x0,5 → 0x00500093.
  - srai x2,x1,3 (funct 1101) → 0x4030D113.
  - sw x2,8(x1) → 0x0020A423.
  - lw x3,-4(x1) → 0xFFC0A183.
  - Addresses 0, 4, 8, 12.
- **LI with backpressure:** li x5,0x12345FFF while `out_ready` is held low for 3 cycles.
  - Words: 0x123462B7 then 0xFFF28293.
  - `out_inst` is stable during the stall and `req_ready` is 0 throughout SECOND.
  - `out_addr` advances only on handshakes.
- **LI single word:** li x6,0x00012000 → only 0x00012337. li x7,-1 → only 0xFFF00393.
- **Illegal requests:** each is accepted with no output and `out_addr` unchanged, and `err` rises and stays high.
  - ALU_IMM with imm 2048.
  - ALU_REG with funct 1001.
  - LUI with imm 0x00001001.
  - `req_op` 12.
  - A following NOP still emits 0x00000013.
- **Reset mid-LI:** assert `reset_n` low while in SECOND.
  - Next cycle: `out_valid=0`, `out_addr=BASE_ADDR`, `err=0`.
  - EBREAK afterwards → 0x00100073 at BASE_ADDR.
- **Address wrap:** with ADDR_W=4, stream 5 NOPs → addresses 0, 4, 8, 12, 0.
